// File: rtl/seq_div16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results held until the
// next completed operation. Divide-by-zero short-circuits to a one-cycle result.
module seq_div16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;
    logic             dz_pend;

    logic [WIDTH:0]   r_shift;
    logic             no_borrow;
    logic [WIDTH-1:0] next_r;
    logic [WIDTH-1:0] next_q;

    // The shifted partial remainder keeps its carry-out bit so divisors above 2^(WIDTH-1)
    // still compare correctly; the difference itself always fits in WIDTH bits.
    always_comb begin
        r_shift   = {r_reg, q_reg[WIDTH-1]};
        no_borrow = (r_shift >= {1'b0, d_reg});
        next_r    = no_borrow ? (r_shift[WIDTH-1:0] - d_reg) : r_shift[WIDTH-1:0];
        next_q    = {q_reg[WIDTH-2:0], no_borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StRun: begin
                    q_reg <= next_q;
                    r_reg <= next_r;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state     <= StFin;
                        quotient  <= next_q;
                        remainder <= next_r;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    if (dz_pend) begin
                        // Second cycle of a divide-by-zero; start is not accepted here.
                        dz_pend     <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                        quotient    <= '1;
                        remainder   <= r_reg;
                        state       <= StFin;
                    end else if (start) begin
                        if (divisor == '0) begin
                            dz_pend <= 1'b1;
                            q_reg   <= '0;
                            r_reg   <= dividend;
                            d_reg   <= '0;
                            count   <= '0;
                            state   <= StIdle;
                        end else begin
                            q_reg       <= dividend;
                            r_reg       <= '0;
                            d_reg       <= divisor;
                            count       <= CW'(WIDTH);
                            state       <= StRun;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div16.sv
// Self-checking bench for seq_div16: arithmetic reference model compared every cycle, plus
// directed operations with hand-computed results and latencies.
module tb_seq_div16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;

    seq_div16 #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation finishes a fixed number of edges later with
    // results computed directly by / and %.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_q    = '0;
    logic [15:0] m_r    = '0;
    logic        m_dz   = 1'b0;
    int          m_left = 0;
    logic [15:0] p_q    = '0;
    logic [15:0] p_r    = '0;
    logic        p_dz   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dz   <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_q    <= p_q;
                    m_r    <= p_r;
                    m_dz   <= p_dz;
                end
            end else if (start) begin
                if (divisor == 16'd0) begin
                    m_left <= 1;
                    p_q    <= 16'hFFFF;
                    p_r    <= dividend;
                    p_dz   <= 1'b1;
                end else begin
                    m_left <= 16;
                    m_busy <= 1'b1;
                    m_dz   <= 1'b0;
                    p_q    <= dividend / divisor;
                    p_r    <= dividend % divisor;
                    p_dz   <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("quotient", {16'd0, quotient}, {16'd0, m_q});
        check("remainder", {16'd0, remainder}, {16'd0, m_r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
        if (done === 1'b1) n_done++;
    end

    // Called at a negedge; returns at the negedge after the sampling edge, with the operand
    // inputs scrambled to show the running operation ignores them.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'hA5C3;
        divisor  = 16'h0007;
    endtask

    task automatic finish_check(input string name, input logic [15:0] eq, input logic [15:0] er,
                                input logic edz, input int elat);
        int lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " latency"}, lat, elat);
        check({name, " q"}, {16'd0, quotient}, {16'd0, eq});
        check({name, " r"}, {16'd0, remainder}, {16'd0, er});
        check({name, " dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        check({name, " busy at done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_before;
        int busy_seen;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset q", {16'd0, quotient}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'd4517, 16'd322);
        check("basic busy after accept", {31'd0, busy}, 32'd1);
        finish_check("basic", 16'd14, 16'd9, 1'b0, 16);
        @(negedge clk);
        check("done one cycle", {31'd0, done}, 32'd0);

        launch(16'd65535, 16'd1);   finish_check("65535/1", 16'd65535, 16'd0, 1'b0, 16);
        @(negedge clk);
        launch(16'd65535, 16'd255); finish_check("65535/255", 16'd257, 16'd0, 1'b0, 16);
        @(negedge clk);
        launch(16'd5, 16'd9);       finish_check("5/9", 16'd0, 16'd5, 1'b0, 16);
        @(negedge clk);
        launch(16'd0, 16'd7);       finish_check("0/7", 16'd0, 16'd0, 1'b0, 16);
        @(negedge clk);
        launch(16'd65535, 16'd40000); finish_check("65535/40000", 16'd1, 16'd25535, 1'b0, 16);
        @(negedge clk);

        busy_seen = 0;
        launch(16'd1917, 16'd0);
        if (busy === 1'b1) busy_seen++;
        finish_check("div0", 16'hFFFF, 16'd1917, 1'b1, 1);
        check("div0 busy never high", busy_seen, 0);
        @(negedge clk);
        launch(16'd28, 16'd65);     finish_check("28/65", 16'd0, 16'd28, 1'b0, 16);
        @(negedge clk);

        done_before = n_done;
        launch(16'd22128, 16'd3);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd23645;
        divisor  = 16'd2;
        @(negedge clk);
        start = 1'b0;
        finish_check("ignored start", 16'd7376, 16'd0, 1'b0, 12);
        repeat (20) @(negedge clk);
        check("ignored start single done", n_done - done_before, 1);
        check("ignored start idle", {31'd0, busy}, 32'd0);

        launch(16'd1000, 16'd7);    finish_check("pre b2b", 16'd142, 16'd6, 1'b0, 16);
        launch(16'd32768, 16'd256); finish_check("b2b", 16'd128, 16'd0, 1'b0, 16);
        @(negedge clk);

        launch(16'd4567, 16'd3);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort q", {16'd0, quotient}, 32'd0);
        check("abort r", {16'd0, remainder}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_before = n_done;
        repeat (20) @(negedge clk);
        check("post reset no done", n_done - done_before, 0);
        check("post reset idle", {31'd0, busy}, 32'd0);
        launch(16'd4567, 16'd3);    finish_check("4567/3", 16'd1522, 16'd1, 1'b0, 16);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
